// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB master controller and its requester arbiter.
// Register-file addresses match the 8-register APB slave this controller fronts.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] REG_ADDR_0 = 8'h00;
    localparam logic [7:0] REG_ADDR_1 = 8'h01;
    localparam logic [7:0] REG_ADDR_2 = 8'h02;
    localparam logic [7:0] REG_ADDR_3 = 8'h03;
    localparam logic [7:0] REG_ADDR_4 = 8'h04;
    localparam logic [7:0] REG_ADDR_5 = 8'h05;
    localparam logic [7:0] REG_ADDR_6 = 8'h06;
    localparam logic [7:0] REG_ADDR_7 = 8'h07;

    // Wait counter is never narrower than 5 bits so small TIMEOUT values still fit.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 5) ? 5 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after (ptr+1) mod NUM_REQ.
// The pointer register is owned by the parent so it can be updated only on an accept.
module rr_arbiter
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (enable_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave port between NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
)
(
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    // state  | meaning
    // IDLE   | arbitrate; req_ready pulses to the granted requester
    // SETUP  | psel=1, penable=0 for one cycle
    // ACCESS | psel=penable=1 until pready (or timeout)
    // RESP   | one-cycle rsp_valid to the owner

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    apb_state_e           state_q;
    logic [IDX_W-1:0]     ptr_q, owner_q;
    logic                 psel_q, penable_q, pwrite_q, err_q;
    logic [ADDR_W-1:0]    paddr_q;
    logic [DATA_W-1:0]    pwdata_q, rdata_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IDX_W-1:0]     grant_idx;
    logic                 to_hit;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Gated by preset so no accept strobe is shown for a cycle that reset discards.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .enable_i    ((state_q == IDLE) && !preset),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT);
    logic [TO_W-1:0] cnt_q;
    assign to_hit = !pready && (cnt_q == TO_W'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|grant_oh) begin
                        state_q  <= SETUP;
                        ptr_q    <= grant_idx;
                        owner_q  <= grant_idx;
                        psel_q   <= 1'b1;
                        pwrite_q <= req_write[grant_idx];
                        paddr_q  <= addr_arr[grant_idx];
                        pwdata_q <= wdata_arr[grant_idx];
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                end
                ACCESS: begin
                    if (pready || to_hit) begin
                        state_q              <= RESP;
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        pwrite_q             <= 1'b0;
                        paddr_q              <= '0;
                        pwdata_q             <= '0;
                        rsp_valid_q[owner_q] <= 1'b1;
                        rdata_q              <= (to_hit || pwrite_q) ? '0 : prdata;
                        err_q                <= to_hit || pslverr;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = grant_oh;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: behavioural register-file slave plus a response scoreboard.
module tb_apb_master_arbiter;
    import apb_ctrl_pkg::*;

    localparam int NR = 2;

    logic          pclk = 1'b0;
    logic          preset;
    logic [NR-1:0] req_valid, req_ready, req_write, rsp_valid;
    logic [NR*8-1:0] req_addr, req_wdata;
    logic [7:0]    rsp_rdata, paddr, pwdata, prdata;
    logic          rsp_err, psel, penable, pwrite, pready, pslverr;

    apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Slave model: wait_cfg wait states per access, err_cfg flags pslverr, stall never readies.
    logic [7:0] mem [8];
    int  wait_cfg = 0;
    int  wait_left = 0;
    bit  err_cfg = 0;
    bit  stall = 0;

    assign prdata  = mem[paddr[2:0]];
    assign pready  = (wait_left == 0) && !stall;
    assign pslverr = err_cfg && pready && psel && penable;

    always @(posedge pclk) begin
        if (psel && !penable)
            wait_left <= wait_cfg;
        else if (psel && penable && wait_left != 0)
            wait_left <= wait_left - 1;
        if (psel && penable && pready && pwrite)
            mem[paddr[2:0]] <= pwdata;
    end

    typedef struct {
        int         owner;
        logic [7:0] rdata;
        logic       err;
    } exp_t;
    exp_t sb[$];

    always @(negedge pclk) begin
        if (!preset) begin
            if (|req_ready) begin
                checks++;
                if ($countones(req_ready) != 1) begin
                    errors++;
                    $display("FAIL ready_onehot got=%b", req_ready);
                end
            end
            if (|rsp_valid) begin
                exp_t e;
                logic [NR-1:0] ov;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp rsp_valid=%b", rsp_valid);
                end else begin
                    e  = sb.pop_front();
                    ov = 2'b01 << e.owner;
                    if (rsp_valid !== ov || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rsp got valid=%b rdata=%h err=%b exp valid=%b rdata=%h err=%b",
                                 rsp_valid, rsp_rdata, rsp_err, ov, e.rdata, e.err);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int o, input logic [7:0] d, input logic er);
        exp_t e;
        e.owner = o; e.rdata = d; e.err = er;
        sb.push_back(e);
    endtask

    // Entered just after a posedge; returns just after the accepting posedge.
    task automatic issue(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bit ok = 0;
        req_write[i] = wr;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge pclk);
            if (req_ready[i]) ok = 1;
        end
        @(posedge pclk); #1;
        req_valid[i] = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_accept req=%0d never got ready", i);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge pclk);
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs psel=%b pen=%b paddr=%h rsp_valid=%b rdata=%h exp all 0",
                     psel, penable, paddr, rsp_valid, rsp_rdata);
        end
        @(posedge pclk); #1;
        preset = 1'b0;
    endtask

    task automatic test_write();
        req_write[0] = 1'b1; req_addr[7:0] = REG_ADDR_2; req_wdata[7:0] = 8'hA5;
        req_valid[0] = 1'b1;
        @(negedge pclk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL wr_ready got=%b exp=01", req_ready);
        end
        push_exp(0, 8'h00, 1'b0);
        @(posedge pclk); #1;
        req_valid[0] = 1'b0;
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 8'h02, 8'hA5}) begin
            errors++;
            $display("FAIL wr_setup psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h exp 1 0 1 02 A5",
                     psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, paddr, pwdata} !== {1'b1, 1'b1, 8'h02, 8'hA5}) begin
            errors++;
            $display("FAIL wr_access psel=%b pen=%b paddr=%h pwdata=%h exp 1 1 02 A5",
                     psel, penable, paddr, pwdata);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 2'b01 || psel !== 1'b0 || paddr !== 8'h00) begin
            errors++;
            $display("FAIL wr_resp rsp_valid=%b psel=%b paddr=%h exp 01 0 00", rsp_valid, psel, paddr);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL wr_rsp_pulse rsp_valid=%b exp=00", rsp_valid);
        end
        @(posedge pclk); #1;
        drain();
    endtask

    task automatic test_readback();
        push_exp(1, 8'hA5, 1'b0);
        issue(1, 1'b0, REG_ADDR_2, 8'h00);
        drain();
    endtask

    task automatic test_contention();
        int got[$];
        int exp_order[4] = '{0, 1, 0, 1};
        req_write = 2'b01;
        req_addr  = {REG_ADDR_3, REG_ADDR_3};
        req_wdata = {8'h00, 8'h11};
        push_exp(0, 8'h00, 1'b0);
        push_exp(1, 8'h11, 1'b0);
        push_exp(0, 8'h00, 1'b0);
        push_exp(1, 8'h11, 1'b0);
        req_valid = 2'b11;
        for (int n = 0; n < 60 && got.size() < 4; n++) begin
            @(negedge pclk);
            if (|req_ready) got.push_back(req_ready[1] ? 1 : 0);
        end
        @(posedge pclk); #1;
        req_valid = 2'b00;
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL rr_count got=%0d exp=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] != exp_order[k]) begin
                    errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, got[k], exp_order[k]);
                end
            end
        end
        drain();
    endtask

    task automatic test_wait_states();
        wait_cfg = 3; err_cfg = 1;
        push_exp(0, 8'hA5, 1'b1);
        issue(0, 1'b0, REG_ADDR_2, 8'h00);
        @(negedge pclk);
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            checks++;
            if ({psel, penable, paddr, rsp_valid} !== {1'b1, 1'b1, 8'h02, 2'b00}) begin
                errors++;
                $display("FAIL wait_hold cyc=%0d psel=%b pen=%b paddr=%h rsp_valid=%b exp 1 1 02 00",
                         k, psel, penable, paddr, rsp_valid);
            end
        end
        @(negedge pclk);
        checks++;
        if (penable !== 1'b0 || rsp_valid !== 2'b01) begin
            errors++; $display("FAIL wait_end pen=%b rsp_valid=%b exp 0 01", penable, rsp_valid);
        end
        @(posedge pclk); #1;
        wait_cfg = 0; err_cfg = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        wait_cfg = 10;
        issue(0, 1'b0, REG_ADDR_2, 8'h00);
        repeat (3) @(negedge pclk);
        @(posedge pclk); #1;
        preset = 1'b1; wait_cfg = 0;
        @(posedge pclk); #1;
        preset = 1'b0;
        req_write = 2'b00;
        req_addr  = {REG_ADDR_2, REG_ADDR_2};
        push_exp(0, 8'hA5, 1'b0);
        push_exp(1, 8'hA5, 1'b0);
        req_valid = 2'b11;
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs psel=%b pen=%b paddr=%h rsp_valid=%b rdata=%h err=%b exp all 0",
                     psel, penable, paddr, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_mid_priority got=%b exp=01", req_ready);
        end
        @(posedge pclk); #1;
        req_valid[0] = 1'b0;
        issue(1, 1'b0, REG_ADDR_2, 8'h00);
        drain();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int acc = 0;
        bit seen = 0;
        stall = 1;
        push_exp(0, 8'h00, 1'b1);
        issue(0, 1'b0, REG_ADDR_2, 8'h00);
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge pclk);
            if (penable) acc++;
            if (|rsp_valid) seen = 1;
        end
        checks++;
        if (acc != 16 || !seen) begin
            errors++; $display("FAIL timeout_len access_cycles=%0d seen=%0d exp 16 1", acc, seen);
        end
        @(posedge pclk); #1;
        stall = 0;
        drain();
    endtask
`endif

    initial begin
        for (int k = 0; k < 8; k++) mem[k] = 8'h00;
        test_reset();
        test_write();
        test_readback();
        test_contention();
        test_wait_states();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master controller that shares one APB slave port (the 8-register, 8-bit-address register file) between NUM_REQ local requesters.
- Round-robin arbitration; each accepted request is sequenced through APB SETUP and ACCESS phases.
- Read data and slave error are returned to the owning requester.
- Sits between processor/DMA-side request ports and the register-file APB slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT, 16, ACCESS-phase wait limit in cycles (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  clock, rising edge.
- preset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to owner.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- psel, penable, pwrite  out  1  APB controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (preset high at a clock edge):
  - all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - An in-flight transfer is abandoned: no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid, grant the first requester at or after (ptr+1) mod NUM_REQ whose valid is set.
  - req_ready[grant] = 1 combinationally in that cycle (one-hot, never more than one bit).
  - Latch write/addr/wdata and owner index, set ptr = grant, go to SETUP.
  - Otherwise stay in IDLE.
- Requester protocol: hold valid and payload stable until ready is seen. Deasserting valid before ready is legal and drops the request.
- SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata from latched request; then go to ACCESS.
- ACCESS:
  - psel=1, penable=1, address/data held stable.
  - On pready=1: capture prdata (reads only; writes capture 0) and pslverr, go to RESP.
  - pready=0: wait state, stay in ACCESS.
- RESP (1 cycle):
  - psel=penable=0; rsp_valid[owner]=1; rsp_rdata and rsp_err driven from the captures; go to IDLE.
  - rsp_rdata and rsp_err hold their last values otherwise; rsp_valid is 0 outside RESP.
- Latency with zero wait states: accept at cycle T, SETUP T+1, ACCESS T+2, RESP T+3, next accept T+4. Peak throughput is 1 transfer per 4 cycles.
- Arbitration:
  - Requests arriving while busy wait; no preemption.
  - A single persistent requester is re-granted every transfer.
- Addresses pass through unchanged; out-of-range handling belongs to the slave.
- paddr/pwrite/pwdata are driven 0 whenever psel=0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - 5-bit-minimum counter (clog2(TIMEOUT+1)) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT, the transfer ends: go to RESP with rsp_err=1 and rsp_rdata=0, then return to IDLE.
  - A pready arriving in that same cycle takes precedence (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_ctrl_pkg:
  - state typedef enum {IDLE, SETUP, ACCESS, RESP}.
  - default ADDR_W/DATA_W constants.
  - register-file address constants 8'h00..8'h07.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, ptr, enable; outputs one-hot grant and grant index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Write: req0 valid, write=1, addr 8'h02, wdata 8'hA5, pready tied 1 -> psel at T+1, penable at T+2 with paddr 02/pwdata A5; rsp_valid[0] at T+3, rsp_err=0.
- Read-back: req1 read addr 8'h02 after the write above, slave returns 8'hA5 -> rsp_valid[1] pulse with rsp_rdata=8'hA5.
- Contention: req0 and req1 both held valid for 4 transfers -> grant order 0,1,0,1; req_ready never has two bits set.
- Wait states: pready low for 3 ACCESS cycles -> psel/penable/paddr stable for 4 ACCESS cycles, then RESP; pslverr=1 at completion -> rsp_err=1.
- Timeout (APB_TIMEOUT_EN, TIMEOUT=16): pready held 0 -> exit after 16 wait cycles with rsp_err=1, rsp_rdata=0; FSM returns to IDLE.
- Reset mid-ACCESS: assert preset for 1 cycle -> next edge all outputs 0, no rsp_valid; a pending req0 is re-accepted in IDLE with priority reset to requester 0.
